// File: rtl/regalu_sequencer.sv
// regalu_sequencer: buffers register-level commands in a small FIFO and
// issues one registered control word per clock to the register-file/ALU
// datapath. Supports ALU ops, flag-only compares, immediate loads and a
// multi-cycle register-range clear.
module regalu_sequencer #(
  parameter int         DEPTH    = 4,
  parameter logic [4:0] FS_PASSB = 5'b00100,
  parameter logic [4:0] FS_AND   = 5'b00000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_da,
  input  logic [4:0]  cmd_sa,
  input  logic [4:0]  cmd_sb,
  input  logic [4:0]  cmd_fs,
  input  logic        cmd_bs,
  input  logic [63:0] cmd_imm,
  input  logic [4:0]  cmd_cnt,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic        W,
  output logic        BS,
  output logic [4:0]  FS,
  output logic [63:0] K,
  input  logic [3:0]  status,
  output logic [3:0]  flags,
  output logic        flags_valid,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_MOVI = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  fs;
    logic        bs;
    logic [63:0] imm;
    logic [4:0]  cnt;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLR} state_t;

  cmd_t        r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  state_t      r_state, w_nstate;
  logic [4:0]  r_da, r_sa, r_sb, r_fs, r_cnt;
  logic [4:0]  w_da, w_sa, w_sb, w_fs, w_cnt;
  logic        r_w, r_bs, r_cmp, w_w, w_bs, w_cmp;
  logic [63:0] r_k, w_k;
  logic [3:0]  r_flags;
  logic        r_flags_valid;
  logic        w_empty, w_full, w_push, w_pop;
  cmd_t        w_head;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign cmd_ready = !w_full && !reset;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= '{op: cmd_op, da: cmd_da, sa: cmd_sa, sb: cmd_sb,
                                 fs: cmd_fs, bs: cmd_bs, imm: cmd_imm, cnt: cmd_cnt};
  end

  // FIFO pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Next control word: continue a range clear, else pop the next command,
  // else fall back to an all-zero (no-write) word.
  always_comb begin
    w_nstate = S_IDLE;
    w_da  = '0;
    w_sa  = '0;
    w_sb  = '0;
    w_fs  = '0;
    w_bs  = 1'b0;
    w_k   = '0;
    w_w   = 1'b0;
    w_cmp = 1'b0;
    w_cnt = r_cnt;
    w_pop = 1'b0;
    if (r_state == S_CLR && r_cnt != 5'd0) begin
      w_nstate = S_CLR;
      w_da  = r_da + 5'd1;
      w_fs  = FS_AND;
      w_bs  = 1'b1;
      w_w   = 1'b1;
      w_cnt = r_cnt - 5'd1;
    end else if (!w_empty) begin
      w_pop = 1'b1;
      w_da  = w_head.da;
      case (w_head.op)
        OP_ALU, OP_CMP: begin
          w_nstate = S_EXEC;
          w_sa  = w_head.sa;
          w_sb  = w_head.sb;
          w_fs  = w_head.fs;
          w_bs  = w_head.bs;
          w_k   = w_head.imm;
          w_w   = (w_head.op == OP_ALU);
          w_cmp = (w_head.op == OP_CMP);
        end
        OP_MOVI: begin
          w_nstate = S_EXEC;
          w_fs  = FS_PASSB;
          w_bs  = 1'b1;
          w_k   = w_head.imm;
          w_w   = 1'b1;
        end
        default: begin
          w_nstate = S_CLR;
          w_fs  = FS_AND;
          w_bs  = 1'b1;
          w_w   = 1'b1;
          w_cnt = w_head.cnt;
        end
      endcase
    end
  end

  // State and registered control word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_da    <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_fs    <= '0;
      r_bs    <= 1'b0;
      r_k     <= '0;
      r_w     <= 1'b0;
      r_cmp   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_da    <= w_da;
      r_sa    <= w_sa;
      r_sb    <= w_sb;
      r_fs    <= w_fs;
      r_bs    <= w_bs;
      r_k     <= w_k;
      r_w     <= w_w;
      r_cmp   <= w_cmp;
      r_cnt   <= w_cnt;
    end
  end

  // Capture datapath status at the end of a compare cycle only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flags       <= '0;
      r_flags_valid <= 1'b0;
    end else begin
      r_flags_valid <= r_cmp;
      if (r_cmp) r_flags <= status;
    end
  end

  assign DA          = r_da;
  assign SA          = r_sa;
  assign SB          = r_sb;
  assign W           = r_w;
  assign BS          = r_bs;
  assign FS          = r_fs;
  assign K           = r_k;
  assign flags       = r_flags;
  assign flags_valid = r_flags_valid;
  assign busy        = !w_empty || (r_state != S_IDLE);
endmodule

// File: doc/regalu_sequencer.md
# regalu_sequencer

Command-driven controller for the 32x64 register-file/ALU datapath. Buffers register-level commands from an upstream requester in a small FIFO and issues one registered control word per clock (DA, SA, SB, W, BS, FS, K) to the datapath. Supports single ALU operations, immediate loads, flag-only compares, and a multi-cycle register-range clear. Sits between the instruction/decode logic and the datapath; it is the datapath's only source of control.

## Interface
Parameters:
- DEPTH, 4: command FIFO depth (power of 2, ≥2).
- FS_PASSB, 5'b00100: ALU function code that passes B to the result (MOVI).
- FS_AND, 5'b00000: ALU function code for A AND B (CLR, with K=0).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears FIFO, FSM and all outputs.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; = !full and !reset.
- cmd_op  in  2  00 ALU, 01 CMP, 10 CLR, 11 MOVI.
- cmd_da, cmd_sa, cmd_sb  in  5  register numbers.
- cmd_fs  in  5  ALU function (ALU/CMP only).
- cmd_bs  in  1  B-select (ALU/CMP only).
- cmd_imm  in  64  immediate to K (ALU/CMP when cmd_bs=1, MOVI).
- cmd_cnt  in  5  CLR: number of extra registers after cmd_da.
- DA, SA, SB  out  5  datapath register selects, registered.
- W  out  1  datapath write enable, registered.
- BS  out  1  datapath B mux select, registered.
- FS  out  5  ALU function, registered.
- K  out  64  constant, registered.
- status  in  4  datapath ALU status for the current control word.
- flags  out  4  status latched from last CMP.
- flags_valid  out  1  one-cycle pulse when flags update.
- busy  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- FIFO: push on cmd_valid && cmd_ready. When full, cmd_ready=0 even if a pop occurs that cycle. Pop/push same cycle when not full: both take effect.
- FSM states: IDLE, EXEC, CLR. Pop occurs on an edge where state is IDLE, EXEC, or CLR with counter==0, and FIFO is non-empty. Popped command is loaded into output registers:
  - ALU: DA/SA/SB/FS/BS from cmd, K=cmd_imm, W=1 -> EXEC.
  - CMP: as ALU but W=0; arm flag capture -> EXEC.
  - MOVI: DA=cmd_da, SA=SB=0, BS=1, FS=FS_PASSB, K=cmd_imm, W=1 -> EXEC.
  - CLR: DA=cmd_da, SA=SB=0, BS=1, FS=FS_AND, K=0, W=1, counter=cmd_cnt -> CLR.
- No pop available in IDLE/EXEC/CLR-done: go IDLE; all control outputs 0 (W=0).
- CLR with counter≠0: DA<=DA+1 (mod 32, 31 wraps to 0), counter--, W stays 1. cnt=n writes n+1 registers in n+1 cycles.
- CMP: at the edge ending the CMP cycle, flags<=status; flags_valid=1 for the following cycle only. Other ops leave flags unchanged.

## Timing
- Reset values: DA=SA=SB=0, W=0, BS=0, FS=0, K=0, flags=0, flags_valid=0, busy=0, cmd_ready=0 while reset high, 1 after release; FIFO empty; state IDLE.
- Command accepted at edge E0 with empty FIFO and FSM IDLE: control word on outputs E1..E2; datapath write at E2; CMP flags valid from E2, flags_valid high E2..E3.
- Back-to-back: one command issued per cycle, no bubbles, while the FIFO is non-empty; CLR occupies cnt+1 cycles.
- Reset mid-CLR or mid-issue: outputs drop to 0 immediately (async); queued commands are discarded; no further writes.
- status is used only in CMP cycles; it is never registered otherwise.

## Test plan
- Reset then ALU cmd (da=3, sa=1, sb=2, fs=5'b01000, bs=0): W=1, DA=3 exactly one cycle, E1..E2; busy falls at E2.
- MOVI da=7 imm=64'hDEAD_BEEF then ALU da=8 sa=7 bs=1 imm=0 fs=FS_PASSB: two consecutive write cycles, K=DEAD_BEEF then 0, no idle cycle between.
- CLR da=30 cnt=3: W=1 for 4 cycles, DA=30,31,0,1; FS=FS_AND, BS=1, K=0 throughout.
- CMP with status driven 4'b1010: flags=4'b1010 and flags_valid pulsed one cycle after the CMP cycle; W=0 during CMP.
- Hold cmd_valid=1 with stalled CLR cnt=31: cmd_ready drops after DEPTH pushes, no command lost or duplicated; all issue in order.
- Assert reset during CLR cycle 2 of cnt=5: W, DA, K go 0 immediately, busy=0, no writes after release until a new command.
